seq_divider: RTL and testbench

Multi-cycle signed 32-bit divider for the datapath: the inverse of the ALU's multiply path, delivering quotient and remainder in the HI/LO convention (Chigh = remainder, Clow = quotient). It performs non-restoring division one quotient bit per clock, behind a start/busy/done handshake. The control unit issues DIV here and stalls until `done`, then loads HI from Chigh and LO from Clow.

---
 rtl/seq_divider_if.sv | 34 +++
 rtl/seq_divider.sv | 153 +++++++++++++++
 tb/tb_seq_divider.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Handshake and data bundle between the control unit and the sequential divider.
//
//   start     control -> divider  request a division (sampled only while idle)
//   A, B      control -> divider  signed dividend / divisor
//   Chigh     divider -> control  remainder (HI)
//   Clow      divider -> control  quotient  (LO)
//   busy      divider -> control  operation in progress
//   done      divider -> control  one-cycle result strobe
//   div_zero  divider -> control  last result came from a zero divisor
// -----------------------------------------------------------------------------
interface seq_divider_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] Chigh;
   logic [WIDTH-1:0] Clow;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (
      output start, A, B,
      input  Chigh, Clow, busy, done, div_zero
   );

   modport slave (
      input  start, A, B,
      output Chigh, Clow, busy, done, div_zero
   );
endinterface

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle signed divider, one quotient bit per clock (non-restoring).
// Results follow the HI/LO convention: Chigh = remainder, Clow = quotient.
// Division truncates toward zero; the remainder takes the dividend's sign.
//
//   clock  in   rising-edge clock
//   clear  in   synchronous active-high reset, highest priority
//   bus    slave side of seq_divider_if (start/A/B in; Chigh/Clow/busy/done/
//          div_zero out)
//
// Timeline (e0 = edge accepting start): LOAD at e1, ITER e2..e(WIDTH+1),
// CORRECT writes the result at e(WIDTH+2). A zero divisor writes at e1.
// -----------------------------------------------------------------------------
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic        clock,
   input  logic        clear,
   seq_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, LOAD, ITER, CORRECT} state_t;

   state_t           state_q, state_d;
   logic             busy_d, done_d;
   logic [CW-1:0]    count;

   // Working registers of the iteration
   logic [WIDTH-1:0] a_reg, b_reg;     // operands as captured at e0
   logic [WIDTH-1:0] q_reg;            // dividend magnitude shifting into quotient
   logic [WIDTH-1:0] m_reg;            // divisor magnitude
   logic [WIDTH:0]   r_reg;            // signed partial remainder, one guard bit
   logic             sign_q, sign_r;

   logic             b_zero;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   r_shift, r_step;
   logic [WIDTH-1:0] rem_mag, quot, rem;

   // Magnitudes; -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct
   // unsigned magnitude.
   assign b_zero  = (b_reg == '0);
   assign a_abs   = a_reg[WIDTH-1] ? -a_reg : a_reg;
   assign b_abs   = b_reg[WIDTH-1] ? -b_reg : b_reg;

   // Non-restoring step: subtract while the remainder is non-negative, add
   // back while it is negative; the new quotient bit is the inverted sign.
   assign r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
   assign r_step  = r_reg[WIDTH] ? (r_shift + {1'b0, m_reg})
                                 : (r_shift - {1'b0, m_reg});

   // Final correction; the corrected remainder is below M, so WIDTH bits hold it.
   assign rem_mag = r_reg[WIDTH] ? (r_reg[WIDTH-1:0] + m_reg) : r_reg[WIDTH-1:0];
   assign quot    = sign_q ? -q_reg   : q_reg;
   assign rem     = sign_r ? -rem_mag : rem_mag;

   // State register
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clock) begin
      if (clear) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state and handshake decode
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d = state_q;
      busy_d  = bus.busy;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = LOAD;
               busy_d  = 1'b1;
            end
         end
         LOAD: begin
            if (b_zero) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = ITER;
            end
         end
         ITER: begin
            if (count == CW'(WIDTH - 1)) state_d = CORRECT;
         end
         CORRECT: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs, result registers and iteration counter
   always_ff @(posedge clock) begin
      if (clear) begin
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.Chigh    <= '0;
         bus.Clow     <= '0;
         bus.div_zero <= 1'b0;
         count        <= '0;
      end else begin
         bus.busy <= busy_d;
         bus.done <= done_d;
         if (state_q == LOAD)      count <= '0;
         else if (state_q == ITER) count <= count + CW'(1);
         if (state_q == LOAD && b_zero) begin
            bus.Clow     <= '1;
            bus.Chigh    <= a_reg;
            bus.div_zero <= 1'b1;
         end else if (state_q == CORRECT) begin
            bus.Clow     <= quot;
            bus.Chigh    <= rem;
            bus.div_zero <= 1'b0;
         end
      end
   end

   // Datapath working registers
   // NOTE: these carry no reset; each is loaded in IDLE/LOAD before it is
   // read, and the state register alone decides whether they matter.
   always_ff @(posedge clock) begin
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_reg <= bus.A;
               b_reg <= bus.B;
            end
         end
         LOAD: begin
            sign_q <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
            sign_r <= a_reg[WIDTH-1];
            q_reg  <= a_abs;
            m_reg  <= b_abs;
            r_reg  <= '0;
         end
         ITER: begin
            r_reg <= r_step;
            q_reg <= {q_reg[WIDTH-2:0], ~r_step[WIDTH]};
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider: table of division vectors plus
// hand-written sequences for handshake, back-to-back and clear corner cases.
// Expected results travel through a scoreboard queue from issue to done.
// -----------------------------------------------------------------------------
module tb_seq_divider;
   localparam int WIDTH = 32;

   logic clock = 1'b0;
   logic clear;

   int checks = 0;
   int errors = 0;

   seq_divider_if #(.WIDTH(WIDTH)) bus ();

   seq_divider #(.WIDTH(WIDTH)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } vec_t;

   exp_t        sbq[$];
   logic [31:0] last_q;
   logic [31:0] last_r;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] q, input logic [31:0] r, input logic dz);
      exp_t e;
      e.q  = q;
      e.r  = r;
      e.dz = dz;
      sbq.push_back(e);
   endtask

   // Caller is mid-cycle; the next rising edge is e0.
   task automatic start_div(input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      bus.A     = $urandom;
      bus.B     = $urandom;
   endtask

   // Returns the index (relative to the last edge before the call) of the
   // edge after which done was observed high.
   task automatic wait_done(input string name, output int edge_idx);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (bus.done !== 1'b1 && n < 100);
      edge_idx = n - 1;
      if (bus.done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: done not seen within %0d cycles", name, n);
      end
   endtask

   task automatic compare_result(input string name);
      exp_t e;
      if (sbq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_sb: result with empty scoreboard", name);
      end else begin
         e = sbq.pop_front();
         check({name, "_quot"}, bus.Clow, e.q);
         check({name, "_rem"},  bus.Chigh, e.r);
         check({name, "_dz"},   {31'b0, bus.div_zero}, {31'b0, e.dz});
         last_q = e.q;
         last_r = e.r;
      end
   endtask

   task automatic watch_no_done(input string name, input int cycles);
      int spurious = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clock);
         if (bus.done === 1'b1) spurious++;
      end
      check({name, "_no_done"}, spurious, 0);
   endtask

   task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r, input logic dz);
      int lat;
      @(negedge clock);
      push_exp(q, r, dz);
      start_div(a, b);
      check({name, "_busy_e0"}, {31'b0, bus.busy}, 32'd1);
      wait_done(name, lat);
      check({name, "_latency"}, lat, (b == 32'd0) ? 32'd1 : 32'd34);
      check({name, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
      compare_result(name);
      @(negedge clock);
      check({name, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
   endtask

   vec_t vecs[9];

   initial begin
      int lat;
      int sa, sb;
      logic [31:0] ra, rb;

      vecs[0] = '{"u100_7",    32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      vecs[1] = '{"n100_7",    32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
      vecs[2] = '{"p100_n7",   32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0};
      vecs[3] = '{"n100_n7",   32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
      vecs[4] = '{"ovf",       32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
      vecs[5] = '{"maxpos_1",  32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   32'd0,          1'b0};
      vecs[6] = '{"small_5_9", 32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
      vecs[7] = '{"divzero",   32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1};
      vecs[8] = '{"after_dz",  32'd9,          32'd3,          32'd3,          32'd0,          1'b0};

      // Reset state
      clear     = 1'b1;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      repeat (3) @(posedge clock);
      #1;
      clear = 1'b0;
      @(negedge clock);
      check("rst_chigh", bus.Chigh, 32'd0);
      check("rst_clow",  bus.Clow,  32'd0);
      check("rst_busy",  {31'b0, bus.busy},     32'd0);
      check("rst_done",  {31'b0, bus.done},     32'd0);
      check("rst_dz",    {31'b0, bus.div_zero}, 32'd0);

      // Table-driven vectors
      for (int i = 0; i < 9; i++)
         run_div(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);

      // Random vectors against a truncating-division model
      for (int i = 0; i < 4; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 28);
         if (rb == 32'd0) rb = 32'd3;
         if ($urandom_range(0, 1) == 1) rb = -rb;
         sa = ra;
         sb = rb;
         run_div("random", ra, rb, 32'(sa / sb), 32'(sa % sb), 1'b0);
      end

      // Start re-pulsed with new operands at e10 is ignored
      @(negedge clock);
      push_exp(32'd14, 32'd2, 1'b0);
      start_div(32'd100, 32'd7);
      repeat (9) @(posedge clock);
      #1;
      bus.start = 1'b1;
      bus.A     = 32'd55;
      bus.B     = 32'd3;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      bus.A     = 32'hDEADBEEF;
      bus.B     = 32'd0;
      @(negedge clock);
      check("ign_hold_clow",  bus.Clow,  last_q);
      check("ign_hold_chigh", bus.Chigh, last_r);
      check("ign_busy", {31'b0, bus.busy}, 32'd1);
      wait_done("ign", lat);
      check("ign_latency", lat + 11, 32'd34);
      compare_result("ign");
      watch_no_done("ign", 40);

      // Back-to-back: start during the done cycle is accepted
      @(negedge clock);
      push_exp(32'd14, 32'd2, 1'b0);
      start_div(32'd100, 32'd7);
      wait_done("b2b_first", lat);
      compare_result("b2b_first");
      push_exp(32'd3, 32'd0, 1'b0);
      start_div(32'd9, 32'd3);
      wait_done("b2b_second", lat);
      check("b2b_spacing", lat + 1, 32'd35);
      compare_result("b2b_second");

      // Leave div_zero set so the mid-operation clear has something to undo
      run_div("dz_pre_clear", 32'hCAFEF00D, 32'd0, 32'hFFFFFFFF, 32'hCAFEF00D, 1'b1);

      // Clear asserted at e20 aborts the operation
      @(negedge clock);
      start_div(32'd100, 32'd7);
      repeat (19) @(posedge clock);
      #1;
      clear = 1'b1;
      @(posedge clock);
      #1;
      clear = 1'b0;
      check("clr_busy",  {31'b0, bus.busy},     32'd0);
      check("clr_done",  {31'b0, bus.done},     32'd0);
      check("clr_chigh", bus.Chigh, 32'd0);
      check("clr_clow",  bus.Clow,  32'd0);
      check("clr_dz",    {31'b0, bus.div_zero}, 32'd0);
      watch_no_done("clr", 40);
      run_div("after_clr", 32'd8, 32'd2, 32'd4, 32'd0, 1'b0);

      // Simultaneous clear and start: start dropped
      @(negedge clock);
      clear = 1'b1;
      start_div(32'd8, 32'd2);
      clear = 1'b0;
      check("clr_start_busy", {31'b0, bus.busy}, 32'd0);
      watch_no_done("clr_start", 40);

      check("sb_drained", sbq.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
